// File: rtl/adc_sequencer_if.sv
// Result-FIFO read/control bus between the ADC sequencer (slave) and the
// Wishbone-side register logic that drains it (master).
interface adc_sequencer_if #(
  parameter int FIFO_DEPTH = 4
) ();
  logic                          rd_en;
  logic                          clear;
  logic [15:0]                   rd_data;
  logic                          rd_valid;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          overflow;

  modport master (
    output rd_en, clear,
    input  rd_data, rd_valid, fifo_level, overflow
  );

  modport slave (
    input  rd_en, clear,
    output rd_data, rd_valid, fifo_level, overflow
  );
endinterface

// File: rtl/adc_sequencer.sv
// SAR ADC front-end: periodic/single-shot start pulse generator plus a
// resynchronised result capture into a show-ahead FIFO.
module adc_sequencer #(
  parameter int START_HIGH = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                enable,
  input  logic                single_shot,
  input  logic [PERIOD_W-1:0] period,
  output logic                start_conversion_out,
  input  logic                conversion_finished_in,
  input  logic [15:0]         result_in,
  output logic                busy,
  adc_sequencer_if.slave      bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (START_HIGH > 1) ? $clog2(START_HIGH) : 1;
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(START_HIGH + 2);

  typedef enum logic [1:0] {IDLE, START, LOW} state_t;

  state_t              state, state_next;
  logic [PERIOD_W-1:0] cnt, cnt_next;
  logic [HW-1:0]       hi_cnt, hi_cnt_next;
  logic [PERIOD_W-1:0] period_eff;

  assign period_eff = (period < MIN_PERIOD) ? MIN_PERIOD : period;
  assign busy       = (state != IDLE);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    hi_cnt_next = hi_cnt;
    unique case (state)
      IDLE: begin
        if (enable || single_shot) begin
          state_next  = START;
          cnt_next    = period_eff - PERIOD_W'(1);
          hi_cnt_next = '0;
        end
      end
      START: begin
        cnt_next = cnt - PERIOD_W'(1);
        if (hi_cnt == HW'(START_HIGH - 1)) begin
          state_next = LOW;
        end else begin
          hi_cnt_next = hi_cnt + HW'(1);
        end
      end
      LOW: begin
        if (cnt == '0) begin
          if (enable) begin
            state_next  = START;
            cnt_next    = period_eff - PERIOD_W'(1);
            hi_cnt_next = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - PERIOD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its peers, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state                <= IDLE;
      cnt                  <= '0;
      hi_cnt               <= '0;
      start_conversion_out <= 1'b0;
    end else begin
      state                <= state_next;
      cnt                  <= cnt_next;
      hi_cnt               <= hi_cnt_next;
      start_conversion_out <= (state == START);
    end
  end

  // Synchroniser flops reset high so a flag already set at release is not an edge.
  logic s1, s2, s3, push;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= conversion_finished_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign push = s2 & ~s3;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, empty, do_push, do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = bus.rd_en & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || bus.clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
      if (push && full && !do_pop) bus.overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by level and
  // the pointers, so resetting the data would only cost flops.
  always_ff @(posedge wb_clk_i) begin
    if (do_push && !bus.clear && !wb_rst_i) begin
      mem[wr_ptr] <= result_in;
    end
  end

  assign bus.rd_data    = empty ? 16'h0000 : mem[rd_ptr];
  assign bus.rd_valid   = ~empty;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed self-checking bench for adc_sequencer: start timing, single-shot
// clamp, capture latency, FIFO full/overflow, reset and clear corner cases.
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, single_shot, flag;
  logic [15:0] period, result;
  logic        start, busy;
  int          total = 0;
  int          bad   = 0;

  adc_sequencer_if #(.FIFO_DEPTH(4)) bus ();

  adc_sequencer #(.START_HIGH(2), .FIFO_DEPTH(4), .PERIOD_W(16)) dut (
    .wb_clk_i               (clk),
    .wb_rst_i               (rst),
    .enable                 (enable),
    .single_shot            (single_shot),
    .period                 (period),
    .start_conversion_out   (start),
    .conversion_finished_in (flag),
    .result_in              (result),
    .busy                   (busy),
    .bus                    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic enable;
    logic single_shot;
    logic exp_start;
    logic exp_busy;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flag rising edge with stable data; push lands on the third edge.
  task automatic push_result(input logic [15:0] data);
    result = data;
    flag   = 1'b1;
    repeat (3) tick();
    flag = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"},    32'(start),          32'h0);
    check({tag, "_busy"},     32'(busy),           32'h0);
    check({tag, "_rd_valid"}, 32'(bus.rd_valid),   32'h0);
    check({tag, "_rd_data"},  32'(bus.rd_data),    32'h0);
    check({tag, "_level"},    32'(bus.fifo_level), 32'h0);
    check({tag, "_overflow"}, 32'(bus.overflow),   32'h0);
  endtask

  initial begin
    // Single shot with period=1 clamped to 4: START x2, LOW x2, then IDLE.
    // Repeated requests while busy are ignored.
    vecs[0] = '{enable: 1'b0, single_shot: 1'b1, exp_start: 1'b0, exp_busy: 1'b1};
    vecs[1] = '{enable: 1'b0, single_shot: 1'b0, exp_start: 1'b1, exp_busy: 1'b1};
    vecs[2] = '{enable: 1'b0, single_shot: 1'b1, exp_start: 1'b1, exp_busy: 1'b1};
    vecs[3] = '{enable: 1'b0, single_shot: 1'b1, exp_start: 1'b0, exp_busy: 1'b1};
    vecs[4] = '{enable: 1'b0, single_shot: 1'b0, exp_start: 1'b0, exp_busy: 1'b0};
    vecs[5] = '{enable: 1'b0, single_shot: 1'b0, exp_start: 1'b0, exp_busy: 1'b0};
    vecs[6] = '{enable: 1'b0, single_shot: 1'b0, exp_start: 1'b0, exp_busy: 1'b0};

    rst = 1'b1; enable = 1'b0; single_shot = 1'b0; flag = 1'b0;
    period = 16'd10; result = 16'h0000;
    bus.rd_en = 1'b0; bus.clear = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (3) tick();

    // Continuous mode: rising edges at ticks 2,12,22,32; enable drops after 35.
    enable = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      check($sformatf("cont_start_%0d", i), 32'(start),
            32'((i >= 2 && i <= 33 && ((i - 2) % 10) < 2) ? 1 : 0));
      check($sformatf("cont_busy_%0d", i), 32'(busy), 32'((i <= 40) ? 1 : 0));
      if (i == 35) enable = 1'b0;
    end

    period = 16'd1;
    for (int i = 0; i < 7; i++) begin
      enable      = vecs[i].enable;
      single_shot = vecs[i].single_shot;
      tick();
      check($sformatf("ss_start_%0d", i), 32'(start), 32'(vecs[i].exp_start));
      check($sformatf("ss_busy_%0d", i),  32'(busy),  32'(vecs[i].exp_busy));
    end
    single_shot = 1'b0;

    // Capture latency: valid after the third edge that sees the flag high.
    result = 16'h5566;
    flag   = 1'b1;
    tick();
    check("cap_valid_k", 32'(bus.rd_valid), 32'h0);
    tick();
    check("cap_valid_k1", 32'(bus.rd_valid), 32'h0);
    tick();
    check("cap_valid_k2", 32'(bus.rd_valid),   32'h1);
    check("cap_data",     32'(bus.rd_data),    32'h5566);
    check("cap_level",    32'(bus.fifo_level), 32'h1);
    flag      = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("cap_pop_valid", 32'(bus.rd_valid), 32'h0);
    check("cap_pop_data",  32'(bus.rd_data),  32'h0);
    repeat (3) tick();

    // Five pushes into a four-deep FIFO: last one dropped, overflow sticky.
    push_result(16'h1122);
    push_result(16'h3344);
    push_result(16'h5566);
    push_result(16'h7788);
    push_result(16'h0001);
    check("full_level",    32'(bus.fifo_level), 32'h4);
    check("full_overflow", 32'(bus.overflow),   32'h1);
    check("full_head",     32'(bus.rd_data),    32'h1122);
    bus.rd_en = 1'b1;
    tick(); check("drain_1", 32'(bus.rd_data), 32'h3344);
    tick(); check("drain_2", 32'(bus.rd_data), 32'h5566);
    tick(); check("drain_3", 32'(bus.rd_data), 32'h7788);
    tick(); check("drain_4", 32'(bus.rd_data), 32'h0);
    check("drain_valid", 32'(bus.rd_valid), 32'h0);
    tick();
    bus.rd_en = 1'b0;
    check("pop_empty_level", 32'(bus.fifo_level), 32'h0);
    check("drain_overflow",  32'(bus.overflow),   32'h1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clear_overflow", 32'(bus.overflow), 32'h0);

    // Refill, then push and pop in the same cycle while full.
    push_result(16'hA000);
    push_result(16'hA001);
    push_result(16'hA002);
    push_result(16'hA003);
    check("refill_level", 32'(bus.fifo_level), 32'h4);
    result = 16'hA004;
    flag   = 1'b1;
    tick();
    tick();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    flag      = 1'b0;
    check("pp_level",    32'(bus.fifo_level), 32'h4);
    check("pp_overflow", 32'(bus.overflow),   32'h0);
    check("pp_head",     32'(bus.rd_data),    32'hA001);
    repeat (3) tick();
    bus.rd_en = 1'b1;
    tick(); check("pp_drain_1", 32'(bus.rd_data), 32'hA002);
    tick(); check("pp_drain_2", 32'(bus.rd_data), 32'hA003);
    tick(); check("pp_drain_3", 32'(bus.rd_data), 32'hA004);
    tick(); check("pp_drain_4", 32'(bus.rd_valid), 32'h0);
    bus.rd_en = 1'b0;
    check("pp_overflow_end", 32'(bus.overflow), 32'h0);

    // Flag held high through reset produces no capture.
    result = 16'hDEAD;
    flag   = 1'b1;
    rst    = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_flag_valid", 32'(bus.rd_valid),   32'h0);
    check("rst_flag_level", 32'(bus.fifo_level), 32'h0);
    flag = 1'b0;
    repeat (3) tick();

    // Reset during START drops the pulse and loses FIFO contents.
    push_result(16'h4242);
    check("pre_rst_level", 32'(bus.fifo_level), 32'h1);
    period = 16'd10;
    enable = 1'b1;
    tick();
    tick();
    check("pre_rst_start", 32'(start), 32'h1);
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'h0);

    // Clear in the same cycle as the push edge discards the entry.
    result = 16'hABCD;
    flag   = 1'b1;
    tick();
    tick();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr_col_level",    32'(bus.fifo_level), 32'h0);
    check("clr_col_valid",    32'(bus.rd_valid),   32'h0);
    check("clr_col_overflow", 32'(bus.overflow),   32'h0);
    repeat (3) tick();
    check("clr_col_later", 32'(bus.fifo_level), 32'h0);
    flag = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
# adc_sequencer

Digital front-end for the SAR ADC macro (`adc_top`) in the user area, running on the Wishbone clock. It generates the periodic `start_conversion` pulses, either free-running or single-shot, and resynchronises the ADC's asynchronous `conversion_finished` flag. On each flag rising edge it captures the 16-bit result into a small show-ahead FIFO that the bus interface drains.

## Interface

Parameters:
- `START_HIGH`, default 2: width of each start pulse, in clock cycles (≥1).
- `FIFO_DEPTH`, default 4: number of result entries (power of 2).
- `PERIOD_W`, default 16: width of the `period` input.

Ports:
- `wb_clk_i`  in  1  system clock; all logic is in this domain.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `enable`  in  1  continuous conversion mode while high.
- `single_shot`  in  1  one-cycle request for exactly one start pulse.
- `period`  in  PERIOD_W  cycles between consecutive start rising edges.
- `clear`  in  1  one-cycle flush of the FIFO and `overflow`.
- `start_conversion_out`  out  1  to ADC `start_conversion_in`.
- `conversion_finished_in`  in  1  from ADC; asynchronous.
- `result_in`  in  16  from ADC `result_out`; stable whenever `conversion_finished_in` is high.
- `rd_en`  in  1  pop the head entry.
- `rd_data`  out  16  head entry (show-ahead); 0 when the FIFO is empty.
- `rd_valid`  out  1  FIFO not empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- `overflow`  out  1  sticky; set when a result was dropped.
- `busy`  out  1  sequencer is not in IDLE.

## Operation

- Effective period: `period_eff = max(period, START_HIGH+2)`. It is sampled only on a reload, so changing `period` mid-run affects the next interval.
- The FSM has three states: IDLE, START and LOW. A down-counter `cnt` is reloaded with `period_eff-1` on entering START.
- **IDLE**
  - Go to START if `enable`, or if `single_shot` is pulsed.
  - Otherwise remain in IDLE.
- **START**
  - `start_conversion_out` is 1 and `cnt` decrements.
  - After `START_HIGH` cycles, go to LOW.
- **LOW**
  - `start_conversion_out` is 0 and `cnt` decrements.
  - When `cnt==0`: go to START (with reload) if `enable`, else go to IDLE.
- `single_shot` is ignored unless the FSM is in IDLE. A single shot runs one full period before returning to IDLE.
- Deasserting `enable` mid-pulse never truncates the pulse: the current START and LOW run to completion.
- Capture path:
  - `conversion_finished_in` passes through a 2-flop synchroniser (s1, s2) plus an edge register s3.
  - A rising edge is `s2 & ~s3`; on it, `result_in` is pushed into the FIFO.
  - Capture is independent of FSM state, so late results are still captured after IDLE.
- FIFO behaviour:
  - Push when full: the data is dropped and `overflow` is set.
  - Push and pop in the same cycle when full: both happen, `overflow` is unchanged, level stays at FULL.
  - `rd_en` when empty: ignored.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `clear`:
  - Empties the FIFO and clears `overflow`.
  - Does not affect the FSM or the synchroniser.
  - A push in the same cycle as `clear` is discarded.
- Oversampling inside the ADC means several start pulses per result. The block does not count them; it captures only when a flag edge occurs.

## Timing

- Reset values:
  - Outputs: `start_conversion_out`=0, `rd_valid`=0, `rd_data`=0, `fifo_level`=0, `overflow`=0, `busy`=0.
  - Internal: FSM in IDLE, `cnt`=0.
  - s1, s2 and s3 reset to 1, so a flag already high at reset release produces no capture.
- Reset mid-operation aborts the pulse immediately: `start_conversion_out` is 0 from the next cycle, and FIFO contents are lost.
- Start timing:
  - `enable` sampled high at edge k in IDLE → `start_conversion_out` is high after edge k+1, for `START_HIGH` cycles.
  - In continuous mode, consecutive rising edges are exactly `period_eff` cycles apart.
- Capture latency: flag first sampled high at edge k → s2 high at k+1 → entry written at k+2 → `rd_valid`=1 after edge k+2.
- Flag pulses shorter than 2 clock cycles are not guaranteed to be captured. The ADC holds the flag high until the next start, so this does not occur in normal use.
- Pop: `rd_en` at edge k → the next entry is on `rd_data` after edge k, with no bubble.

## Test plan

- **Continuous mode:** reset, `period`=10, `enable`=1 for 35 cycles → start rising edges 10 cycles apart, each 2 cycles wide; after `enable`=0 the FSM returns to IDLE at the end of the current period; `busy` tracks the FSM.
- **Period clamp and single shot:** `period`=1, pulse `single_shot` → exactly one 2-cycle start pulse, `busy` high for 4 cycles, then IDLE; a second `single_shot` issued while busy is ignored.
- **Capture:** drive the flag high with `result_in`=16'h5566 → `rd_valid` goes high 3 edges after the first high sample and `rd_data`=16'h5566; `rd_en` → `rd_valid`=0 and `rd_data`=0.
- **Full and overflow:** push 5 results (16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h0001) with no reads → `fifo_level`=4, `overflow`=1, reads return the first four in order. Then fill again and push while popping in the same cycle → `overflow` stays 0 after a `clear`.
- **Reset edge cases:** hold the flag high through `wb_rst_i` → no capture after reset. Assert `wb_rst_i` during START → the pulse drops the next cycle and all outputs return to reset values.
- **Clear collision:** assert `clear` in the same cycle as a flag edge push → FIFO is empty afterwards and `overflow`=0.
